ic_dma_responder: RTL and testbench

- Memory-side responder for the instruction-cache refill DMA port.
- Accepts one 128-bit line read request at a time from ic_dram over the ic_read_dma_valid/addr/ack/data handshake.
- Fetches the line from a backing-memory read port and returns it with a one-cycle ack pulse.
- Sits between ic_dram and the waveform/DRAM storage controller.

---
 rtl/ic_dma_responder_if.sv | 27 ++
 rtl/ic_dma_responder.sv | 168 ++++++++++++++++
 tb/tb_ic_dma_responder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ic_dma_responder_if.sv
// Refill handshake between ic_dram and the responder, plus the backing-memory read port.
// slave is the responder's view; master is the cache-plus-memory side.
interface ic_dma_responder_if #(
  parameter int addr_w = 33,
  parameter int ram_dw = 128,
  parameter int mem_aw = 16
);
  logic              ic_read_dma_valid;
  logic [addr_w-1:0] ic_read_dma_addr;
  logic              ic_read_dma_ack;
  logic [ram_dw-1:0] ic_read_dma_data;
  logic              mem_req;
  logic [mem_aw-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [ram_dw-1:0] mem_rdata;

  modport slave (
    input  ic_read_dma_valid, ic_read_dma_addr, mem_gnt, mem_rvalid, mem_rdata,
    output ic_read_dma_ack, ic_read_dma_data, mem_req, mem_addr
  );

  modport master (
    output ic_read_dma_valid, ic_read_dma_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  ic_read_dma_ack, ic_read_dma_data, mem_req, mem_addr
  );
endinterface

// File: rtl/ic_dma_responder.sv
// Memory-side responder for instruction-cache line refills: one 128-bit line per request.
// Define RESP_TIMEOUT_EN to add the WAIT timeout with a DRAIN state for the late read.
module ic_dma_responder #(
  parameter int addr_w      = 33,
  parameter int ram_dw      = 128,
  parameter int mem_aw      = 16,
  parameter int timeout_cyc = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  ic_dma_responder_if.slave   bus,
  input  logic                err_clr,
  output logic                err_misalign,
  output logic                err_range,
  output logic                err_timeout,
  output logic                busy
);

`ifdef RESP_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;
  localparam int cnt_w = $clog2(timeout_cyc + 1);
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  logic unused_timeout;
  assign unused_timeout = (timeout_cyc > 0);
`endif

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic [ram_dw-1:0] data_q, data_d;
  logic              req_q, req_d;
  logic [mem_aw-1:0] maddr_q, maddr_d;
  logic              busy_q, busy_d;
  logic              mis_q, mis_d, rng_q, rng_d, to_q, to_d;
  logic              set_mis, set_rng, set_to;

  logic [mem_aw-1:0] line_idx;
  logic              out_of_range;

  assign line_idx     = bus.ic_read_dma_addr[mem_aw+3:4];
  assign out_of_range = |bus.ic_read_dma_addr[addr_w-1:mem_aw+4];

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    req_d   = 1'b0;
    maddr_d = maddr_q;
    set_mis = 1'b0;
    set_rng = 1'b0;
    set_to  = 1'b0;
`ifdef RESP_TIMEOUT_EN
    cnt_d   = '0;
    tout_d  = tout_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ic_read_dma_valid) begin
          maddr_d = line_idx;
          set_mis = |bus.ic_read_dma_addr[3:0];
          if (out_of_range) begin
            // Unreachable line: answer with zeros and never touch memory.
            state_d = RESP;
            ack_d   = 1'b1;
            data_d  = '0;
            set_rng = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) state_d = WAIT;
        else             req_d   = 1'b1;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          data_d  = bus.mem_rdata;
          ack_d   = 1'b1;
          state_d = RESP;
        end
`ifdef RESP_TIMEOUT_EN
        else if (cnt_q == cnt_w'(timeout_cyc - 1)) begin
          data_d  = '0;
          ack_d   = 1'b1;
          set_to  = 1'b1;
          tout_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
`ifdef RESP_TIMEOUT_EN
        // The abandoned read is still owed to us; a late beat landing now counts as drained.
        if (tout_q) begin
          tout_d = 1'b0;
          if (!bus.mem_rvalid) state_d = DRAIN;
        end
`endif
      end
`ifdef RESP_TIMEOUT_EN
      DRAIN: begin
        if (bus.mem_rvalid) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    // A new error in the same cycle as err_clr survives the clear.
    mis_d = set_mis | (mis_q & ~err_clr);
    rng_d = set_rng | (rng_q & ~err_clr);
    to_d  = set_to  | (to_q  & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      data_q  <= '0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
      rng_q   <= rng_d;
      to_q    <= to_d;
    end
  end

`ifdef RESP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end
  assign err_timeout = to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign bus.ic_read_dma_ack  = ack_q;
  assign bus.ic_read_dma_data = data_q;
  assign bus.mem_req          = req_q;
  assign bus.mem_addr         = maddr_q;
  assign busy                 = busy_q;
  assign err_misalign         = mis_q;
  assign err_range            = rng_q;

endmodule

// File: tb/tb_ic_dma_responder.sv
// Self-checking bench for ic_dma_responder: directed and randomized refills against a
// transaction-level model of latency, returned line and sticky error flags.
module tb_ic_dma_responder;
  logic clk;
  logic rst_n;
  logic err_clr;
  logic err_misalign, err_range, err_timeout, busy;

  ic_dma_responder_if #(.addr_w(33), .ram_dw(128), .mem_aw(16)) bus ();

  ic_dma_responder #(.addr_w(33), .ram_dw(128), .mem_aw(16), .timeout_cyc(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .err_clr      (err_clr),
    .err_misalign (err_misalign),
    .err_range    (err_range),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // Edge count n: a value registered at posedge n is observed while edge_n == n.
  int           edge_n = 0;
  int           ack_count = 0;
  int           last_ack_edge = -1;
  int           req_cycles = 0;
  int           gnt_cnt = 0;
  logic [15:0]  gnt_addr = '0;
  int           gnt_dly = 0;
  int           rv_dly = 0;
  bit           hold = 0;
  bit           noise = 0;
  bit           mm_clear = 0;
  logic [127:0] salt = '0;
  bit           mis_acc = 0;
  bit           rng_acc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memory contents: line index XOR a per-test salt.
  function automatic logic [127:0] line_data(input logic [15:0] idx);
    return 128'(idx) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Logging only: edge counter, ack pulses, mem_req occupancy.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (bus.mem_req) req_cycles++;
      if (bus.ic_read_dma_ack) begin
        ack_count++;
        last_ack_edge = edge_n;
      end
    end
  end

  // Memory: grant after gnt_dly waiting cycles, read data rv_dly cycles after the earliest slot.
  initial begin
    int ph, seen, wcnt;
    logic [15:0] pend;
    ph = 0; seen = 0; wcnt = 0; pend = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mm_clear) begin
        ph = 0; seen = 0; wcnt = 0; mm_clear = 0;
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      if (ph == 0) begin
        if (bus.mem_req) begin
          if (seen == gnt_dly) begin
            bus.mem_gnt = 1'b1;
            pend = bus.mem_addr;
            gnt_addr = bus.mem_addr;
            gnt_cnt++;
            seen = 0; wcnt = 0; ph = 1;
          end else begin
            seen++;
          end
        end else if (noise) begin
          bus.mem_gnt = 1'($urandom_range(0, 1));
        end
        if (noise) bus.mem_rvalid = 1'($urandom_range(0, 1));
      end else if (!hold) begin
        if (wcnt == rv_dly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = line_data(pend);
          ph = 0;
        end else begin
          wcnt++;
          if (noise) bus.mem_gnt = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // One refill; called and returns at a negedge (returns inside the ack cycle).
  task automatic do_req(input logic [32:0] a, input int gd, input int rd, input bit keep, input bit drop);
    logic [15:0]  idx;
    logic [127:0] exp_data;
    bit           in_rng, got;
    int           k, exp_edge, start;
    idx      = a[19:4];
    in_rng   = (a[32:20] == 13'd0);
    exp_data = in_rng ? line_data(idx) : 128'd0;
    gnt_dly  = gd;
    rv_dly   = rd;
    // During an ack cycle the responder is finishing; it samples valid one edge later.
    k        = bus.ic_read_dma_ack ? edge_n + 2 : edge_n + 1;
    exp_edge = in_rng ? k + 2 + gd + rd : k;
    start    = ack_count;
    req_cycles = 0;
    bus.ic_read_dma_addr  = a;
    bus.ic_read_dma_valid = 1'b1;
    if (a[3:0] != 4'd0) mis_acc = 1;
    if (!in_rng) rng_acc = 1;
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (ack_count != start) got = 1;
      if (drop && !got && edge_n >= k) bus.ic_read_dma_valid = 1'b0;
    end
    chk("ack_seen", 128'(got), 128'd1);
    chk("ack_edge", 128'(last_ack_edge), 128'(exp_edge));
    chk("ack_data", bus.ic_read_dma_data, exp_data);
    chk("req_cycles", 128'(req_cycles), in_rng ? 128'(gd + 1) : 128'd0);
    if (in_rng) chk("mem_addr", 128'(gnt_addr), 128'(idx));
    chk("err_misalign", 128'(err_misalign), 128'(mis_acc));
    chk("err_range", 128'(err_range), 128'(rng_acc));
    if (!keep) bus.ic_read_dma_valid = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mis_acc = 0;
    rng_acc = 0;
    chk("clr_misalign", 128'(err_misalign), 128'd0);
    chk("clr_range", 128'(err_range), 128'd0);
    chk("clr_timeout", 128'(err_timeout), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int start, gd, rd, sel;
    bit keep, drop;
    logic [32:0] a;
    logic [15:0] idx;

    rst_n = 1'b0;
    err_clr = 1'b0;
    bus.ic_read_dma_valid = 1'b0;
    bus.ic_read_dma_addr  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", 128'(bus.ic_read_dma_ack), 128'd0);
    chk("rst_req", 128'(bus.mem_req), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_data", bus.ic_read_dma_data, 128'd0);
    chk("rst_maddr", 128'(bus.mem_addr), 128'd0);
    chk("rst_errs", 128'({err_misalign, err_range, err_timeout}), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Minimum-latency refill of line 0
    salt = 128'hA5;
    do_req(33'h0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_pulse", 128'(bus.ic_read_dma_ack), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("data_held", bus.ic_read_dma_data, 128'hA5);

    // 512 back-to-back refills, grant delayed by 2 cycles
    salt  = '0;
    start = ack_count;
    for (int i = 0; i < 512; i++) do_req(33'(16 * i), 2, 0, 1, 0);
    bus.ic_read_dma_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("b2b_ack_count", 128'(ack_count - start), 128'd512);

    // Out-of-range line: zero data, no memory access, sticky flag, then clear
    do_req(33'h100000, 0, 0, 0, 0);
    clear_errs();

    // Misaligned address served at the aligned line
    salt = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    do_req(33'h13, 1, 1, 0, 0);
    chk("misalign_maddr", 128'(bus.mem_addr), 128'd1);
    clear_errs();

    // Set and clear in the same cycle: the set survives, next clear wins
    err_clr = 1'b1;
    do_req(33'h1_0000_0040, 0, 0, 0, 0);
    @(negedge clk);
    err_clr = 1'b0;
    rng_acc = 0;
    chk("clr_after_set", 128'(err_range), 128'd0);

    // Randomized traffic with protocol noise on gnt/rvalid outside their states
    noise = 1;
    for (int t = 0; t < 60; t++) begin
      salt = {$urandom, $urandom, $urandom, $urandom};
      idx  = 16'($urandom);
      sel  = $urandom_range(0, 3);
      case (sel)
        0:       a = {13'd0, idx, 4'd0};
        1:       a = {13'd0, idx, 4'($urandom_range(1, 15))};
        2:       a = {13'($urandom_range(1, 8191)), idx, 4'($urandom_range(0, 15))};
        default: a = {13'd0, idx, 4'd0};
      endcase
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      keep = ($urandom_range(0, 3) == 0);
      drop = ($urandom_range(0, 4) == 0);
      do_req(a, gd, rd, keep, drop);
      if (!keep) begin
        if ($urandom_range(0, 2) == 0) clear_errs();
        else repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    noise = 0;
    bus.ic_read_dma_valid = 1'b0;
    clear_errs();

    // Reset while waiting for read data: abandoned, no ack, outputs cleared at once
    hold = 1;
    gnt_dly = 0;
    start = ack_count;
    bus.ic_read_dma_addr  = 33'h230;
    bus.ic_read_dma_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("wait_busy", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", 128'(bus.ic_read_dma_ack), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_req", 128'(bus.mem_req), 128'd0);
    chk("arst_data", bus.ic_read_dma_data, 128'd0);
    chk("arst_maddr", 128'(bus.mem_addr), 128'd0);
    bus.ic_read_dma_valid = 1'b0;
    mm_clear = 1;
    hold = 0;
    mis_acc = 0;
    rng_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_ack", 128'(ack_count - start), 128'd0);
    do_req(33'h450, 1, 2, 0, 0);

`ifdef RESP_TIMEOUT_EN
    // Read data withheld: forced zero completion after 8 WAIT cycles, late beat discarded
    repeat (2) @(negedge clk);
    hold = 1;
    gnt_dly = 0;
    rv_dly = 0;
    salt = 128'hDEAD_BEEF;
    begin
      int k;
      bit got;
      start = ack_count;
      k = edge_n + 1;
      bus.ic_read_dma_addr  = 33'h80;
      bus.ic_read_dma_valid = 1'b1;
      got = 0;
      for (int n = 0; n < 60 && !got; n++) begin
        @(negedge clk);
        if (ack_count != start) got = 1;
      end
      chk("to_ack_seen", 128'(got), 128'd1);
      chk("to_ack_edge", 128'(last_ack_edge), 128'(k + 1 + 8));
      chk("to_data", bus.ic_read_dma_data, 128'd0);
      chk("to_flag", 128'(err_timeout), 128'd1);
      bus.ic_read_dma_valid = 1'b0;
      @(negedge clk);
      chk("drain_busy", 128'(busy), 128'd1);
      hold = 0;
      repeat (3) @(negedge clk);
      chk("drain_done", 128'(busy), 128'd0);
      chk("drain_data", bus.ic_read_dma_data, 128'd0);
      chk("drain_no_ack", 128'(ack_count - start), 128'd1);
    end
    clear_errs();
    do_req(33'h90, 0, 0, 0, 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
